// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I instruction encoder.
//   - Instruction format codes as presented on the encoder's fmt input
//   - Output FIFO geometry
//   - Queue entry layout (encoded word plus its error flag)
//   - fits_signed(): immediate range helper used by the packer
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } fifo_entry_t;

    // True when v, read as two's complement, survives truncation to 'bits'
    // bits: everything from the would-be sign bit upward must be all zeros
    // or all ones.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/insn_pack.sv
// Combinational RV32I field packer and immediate range checker.
// Ports:
//   i_fmt      instruction format code (fmt_e; 6 and 7 are illegal)
//   i_opcode   7-bit major opcode
//   i_funct7   7-bit funct7 (R format only)
//   i_funct3   3-bit funct3
//   i_rd/i_rs1/i_rs2  register indices
//   i_imm      raw signed immediate / byte offset
//   o_instr    packed instruction word (0 for an illegal format)
//   o_err      immediate out of range, misaligned, or illegal format
module insn_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [6:0]  i_funct7,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_err
);

    always_comb begin
        o_instr = '0;
        o_err   = 1'b0;
        case (i_fmt)
            FMT_R: begin
                o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            end
            FMT_I: begin
                o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_err   = !fits_signed(i_imm, 12);
            end
            FMT_S: begin
                o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_err   = !fits_signed(i_imm, 12);
            end
            FMT_B: begin
                // Branch offsets are halfword aligned; bit 0 is never encoded.
                o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
                o_err   = !fits_signed(i_imm, 13) || i_imm[0];
            end
            FMT_U: begin
                // Only the upper 20 bits are encodable; low bits must be clear.
                o_instr = {i_imm[31:12], i_rd, i_opcode};
                o_err   = (i_imm[11:0] != 12'd0);
            end
            FMT_J: begin
                o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_err   = !fits_signed(i_imm, 21) || i_imm[0];
            end
            default: begin
                o_instr = '0;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/insn_encoder.sv
// RV32I instruction encoder with a small output queue.
// A request accepted on in_valid/in_ready is packed combinationally and
// queued; the queue head is presented on instr/err with out_valid.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready depends only on state)
//   fmt, opcode, funct7, funct3, rd, rs1, rs2, imm   request fields
//   out_valid / out_ready  output handshake
//   instr, err           queue head word and its error flag (0 when empty)
//   enc_count            accepted requests since reset, wraps at 16 bits
module insn_encoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [15:0] enc_count
);

    fifo_entry_t             r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0]   r_wr_ptr;
    logic [FIFO_PTR_W-1:0]   r_rd_ptr;
    logic [FIFO_CNT_W-1:0]   r_count;
    logic [15:0]             r_enc_count;

    logic [31:0]             w_instr;
    logic                    w_err;
    logic                    w_push;
    logic                    w_pop;

    insn_pack u_pack (
        .i_fmt    (fmt),
        .i_opcode (opcode),
        .i_funct7 (funct7),
        .i_funct3 (funct3),
        .i_rd     (rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_imm    (imm),
        .o_instr  (w_instr),
        .o_err    (w_err)
    );

    // in_ready is purely occupancy based, so a full queue refuses a push
    // even when the head is popped in the same cycle; the freed slot is
    // offered on the following cycle.
    assign in_ready  = (r_count < FIFO_CNT_W'(FIFO_DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Empty queue drives zeros so stale entries never leak after reset.
    assign instr     = out_valid ? r_mem[r_rd_ptr].instr : '0;
    assign err       = out_valid ? r_mem[r_rd_ptr].err   : 1'b0;
    assign enc_count = r_enc_count;

    // Storage needs no reset: occupancy gates everything that reads it.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= '{instr: w_instr, err: w_err};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_enc_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= (r_wr_ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                r_enc_count <= r_enc_count + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_encoder.sv
// Randomised and directed bench for insn_encoder. A queue-based model
// computes every expected word with shifts/masks and signed range checks.
module tb_insn_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [15:0] enc_count;

    always #5 clk = ~clk;

    insn_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .funct7    (funct7),
        .funct3    (funct3),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err),
        .enc_count (enc_count)
    );

    typedef struct {
        bit [31:0] instr;
        bit        err;
    } exp_t;

    exp_t      exp_q[$];
    bit [15:0] m_count;
    int        checks   = 0;
    int        failures = 0;
    bit        verbose  = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%08h want=%08h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input bit [2:0] f, input bit [6:0] op, input bit [4:0] d,
                                   input bit [4:0] s1, input bit [4:0] s2, input bit [2:0] f3,
                                   input bit [6:0] f7, input bit [31:0] im);
        exp_t      e;
        int        si;
        bit [31:0] regs;
        si   = im;
        regs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
        e.instr = 32'h0;
        e.err   = 1'b0;
        case (f)
            3'd0: e.instr = (32'(f7) << 25) | regs | (32'(d) << 7) | 32'(op);
            3'd1: begin
                e.instr = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                        | (32'(d) << 7) | 32'(op);
                e.err   = (si < -2048) || (si > 2047);
            end
            3'd2: begin
                e.instr = (((im >> 5) & 32'h7F) << 25) | regs | ((im & 32'h1F) << 7) | 32'(op);
                e.err   = (si < -2048) || (si > 2047);
            end
            3'd3: begin
                e.instr = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | regs
                        | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'(op);
                e.err   = (si < -4096) || (si > 4095) || ((im & 32'h1) != 0);
            end
            3'd4: begin
                e.instr = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
                e.err   = (im & 32'hFFF) != 0;
            end
            3'd5: begin
                e.instr = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                        | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                        | (32'(d) << 7) | 32'(op);
                e.err   = (si < -1048576) || (si > 1048575) || ((im & 32'h1) != 0);
            end
            default: begin
                e.instr = 32'h0;
                e.err   = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Check outputs against the model, then advance one clock and update it.
    task automatic cycle();
        bit   acc;
        bit   pop;
        exp_t e;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        check("enc_count", 32'(enc_count), 32'(m_count));
        if (exp_q.size() != 0) begin
            check("head_instr", instr, exp_q[0].instr);
            check("head_err", 32'(err), 32'(exp_q[0].err));
        end else begin
            check("idle_instr", instr, 32'h0);
            check("idle_err", 32'(err), 32'h0);
        end
        acc = in_valid && (exp_q.size() < 2) && !rst;
        pop = (exp_q.size() != 0) && out_ready;
        e   = model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_count = 16'd0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(e);
                m_count++;
                if (verbose)
                    $display("txn fmt=%0d imm=%08h -> instr=%08h err=%0d count=%0d",
                             fmt, imm, e.instr, e.err, m_count);
            end
        end
    endtask

    task automatic set_req(input bit [2:0] f, input bit [6:0] op, input bit [4:0] d,
                           input bit [4:0] s1, input bit [4:0] s2, input bit [2:0] f3,
                           input bit [6:0] f7, input bit [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic rand_req();
        bit [31:0] im;
        case ($urandom_range(0, 4))
            0: im = 32'($urandom_range(0, 8191)) - 32'd4096;
            1: im = $urandom;
            2: im = $urandom & 32'hFFFFF000;
            3: im = 32'($urandom_range(0, 2097151)) - 32'h100000;
            default: im = 32'($urandom_range(0, 4095)) & 32'hFFFFFFFE;
        endcase
        set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), 3'($urandom), 7'($urandom), im);
    endtask

    // Single request into an empty queue; result must appear one cycle later.
    task automatic directed(input string tag, input bit [2:0] f, input bit [6:0] op,
                            input bit [4:0] d, input bit [4:0] s1, input bit [4:0] s2,
                            input bit [2:0] f3, input bit [31:0] im,
                            input bit chk_instr, input bit [31:0] want_instr, input bit want_err);
        set_req(f, op, d, s1, s2, f3, 7'd0, im);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'h1);
        if (chk_instr) check({tag, "_instr"}, instr, want_instr);
        check({tag, "_err"}, 32'(err), 32'(want_err));
        cycle();
    endtask

    initial begin
        logic [31:0] held;
        logic [15:0] base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        m_count = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Format coverage and error cases
        out_ready = 1'b1;
        directed("R",  3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0,         1'b1, 32'h002081B3, 1'b0);
        directed("I",  3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF,  1'b1, 32'hFFF00093, 1'b0);
        directed("S",  3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8,         1'b1, 32'h0020A423, 1'b0);
        directed("U",  3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000,  1'b1, 32'h123452B7, 1'b0);
        directed("J",  3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048,      1'b1, 32'h001000EF, 1'b0);
        directed("B4096", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096,   1'b0, 32'h0, 1'b1);
        directed("B3",    3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3,      1'b0, 32'h0, 1'b1);
        directed("F6",    3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 32'd0,      1'b1, 32'h0, 1'b1);

        // Backpressure: three requests against a stalled output
        out_ready = 1'b0;
        rand_req(); in_valid = 1'b1; cycle();
        rand_req(); cycle();
        rand_req(); cycle();
        held = instr;
        cycle();
        check("bp_head_stable", instr, held);
        check("bp_in_ready", 32'(in_ready), 32'h0);
        base = enc_count;
        out_ready = 1'b1;
        cycle();
        check("bp_freed", 32'(in_ready), 32'h1);
        cycle();
        check("bp_third", 32'(enc_count), 32'(base + 16'd1));
        in_valid = 1'b0;
        repeat (3) cycle();

        // Reset with two words queued and a request in the reset cycle
        out_ready = 1'b0;
        rand_req(); in_valid = 1'b1; cycle();
        rand_req(); cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_enc_count", 32'(enc_count), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        cycle();

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rand_req();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        // Counter wrap: 65537 accepts from reset
        rst = 1'b1; in_valid = 1'b0; cycle();
        rst = 1'b0;
        verbose = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1;
        set_req(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        for (int i = 0; i < 65537; i++) cycle();
        in_valid = 1'b0;
        verbose = 1'b1;
        check("wrap_count", 32'(enc_count), 32'h1);
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
